reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Producer side of the RS finish-broadcast protocol consumed by the reorder buffer.
- Holds issued integer/branch/JALR micro-ops until both operands are valid; snoops both result buses (RS and LSB) for pending ROB tags.
- Dispatches one ready entry per cycle to an internal ALU and drives a registered result broadcast (rdy/id/value).
- Sits between the issue stage and the ROB, in parallel with the LSB.

Parameters:
- RoB_BITS, 4, width of ROB tag; must equal the ROB's tag width.
- RS_SIZE, 8, number of station entries.
- RS_BITS, 3, log2(RS_SIZE).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global ready; low freezes all state
- clear  in  1  mispredict flush; drops all entries
- issue_ready  in  1  valid issue this cycle
- issue_opcode  in  7  RV32I opcode
- issue_funct3  in  3  funct3
- issue_funct7_5  in  1  instr[30] (SUB/SRA/SRAI)
- issue_pc  in  32  instruction pc
- issue_imm  in  32  sign-extended immediate
- issue_Vj, issue_Vk  in  32 each  operand values
- issue_Qj_busy, issue_Qk_busy  in  1 each  operand pending
- issue_Qj, issue_Qk  in  RoB_BITS each  producer tags
- issue_rob_id  in  RoB_BITS  destination ROB tag
- cdb1_rdy / cdb1_id / cdb1_value  in  1/RoB_BITS/32  RS result bus, fed back from own output
- cdb2_rdy / cdb2_id / cdb2_value  in  1/RoB_BITS/32  LSB result bus
- full  out  1  no free entry
- RS_finish_rdy  out  1  result valid (registered)
- RS_finish_id  out  RoB_BITS  ROB tag of result
- RS_finish_value  out  32  result

Behaviour:
- Reset (sync, rst_in high at posedge): all entries free; RS_finish_rdy=0, RS_finish_id=0, RS_finish_value=0; full=0. Reset wins over clear and rdy_in.
- rdy_in low: every register holds, including outputs.
- Per-entry state:
  - FREE.
  - WAIT: any Q busy.
  - READY: both Q clear.
  - FREE again at dispatch.
- Issue: when issue_ready, write the lowest-index FREE entry.
  - Issue while full is ignored; no entry is written.
  - Same-cycle CDB bypass: if issue_Qj_busy and cdb1 or cdb2 carries a matching id, store that value with Qj cleared. Same for Qk.
- Operand capture: each cycle, every WAIT entry whose Qj/Qk matches cdb1_id (when cdb1_rdy) or cdb2_id (when cdb2_rdy) latches the value and clears busy. Both buses may resolve different operands in the same cycle.
- Dispatch: select one READY entry (lowest index by default) → entry becomes FREE; result registered. RS_finish_rdy=1 the next cycle (1-cycle latency).
  - With no READY entry, RS_finish_rdy=0.
  - An entry made READY by a capture this cycle is eligible next cycle, not the same cycle.
- ALU results:
  - OP / OP-IMM: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND. Shift amount is [4:0]. Rk = Vk for OP, imm for OP-IMM.
  - LUI = imm.
  - AUIPC = pc + imm.
  - JALR = (Vj + imm) & ~1.
  - BRANCH: 32'd1 if taken else 32'd0, for BEQ/BNE/BLT/BGE/BLTU/BGEU. The ROB XORs this with its prediction.
  - Arithmetic is mod 2^32.
- full = all entries non-FREE, computed combinationally from current state. A same-cycle dispatch does not deassert full early.
- clear (rdy_in high): all entries FREE; RS_finish_rdy=0 next cycle; issue in the same cycle is discarded.
- Simultaneous issue and dispatch of different entries is permitted. Issue may reuse only an entry FREE at cycle start.

Optional Feature:
- RS_AGE_SELECT_EN defined: each entry carries an issue-order age. Dispatch picks the oldest READY entry; ages are renormalised on dispatch and clear.
- Undefined: fixed lowest-index priority.

Decomposition:
- Shared const.v:
  - `RoB_BITS`, RS_SIZE/RS_BITS defines.
  - RV32I opcode constants (OP, OP_IMM, LUI, AUIPC, BRANCH, JALR).
  - funct3 encodings.
- One combinational sub-module, rs_alu (opcode, funct3, funct7_5, Vj, Vk, imm, pc → 32-bit result). Selection and storage stay in reservation_station.

Test Plan:
- ADDI: issue Vj=5, imm=7, both ready, rob_id=3 → cycle+2 RS_finish_rdy=1, id=3, value=12.
- Pending operand: SUB with Qj=2 busy, Vk=1; cdb2 id=2 value=10 two cycles later → finish value 9, not before the capture cycle +1.
- Issue-cycle bypass: issue ADD Qj=4 busy while cdb1_rdy id=4 value=0xFFFF_FFFF, Vk=1 → result 0.
- Fill all 8 entries with Qj busy → full=1; a 9th issue is ignored; capture broadcast → 8 results on consecutive cycles, full drops after the first dispatch.
- BLTU with Vj=1, Vk=0xFFFF_FFFF → value 1; BGE same operands → 1; JALR Vj=0x101, imm=2 → 0x102.
- clear with 3 WAIT entries and a result pending → next cycle RS_finish_rdy=0, full=0; later broadcasts produce no results.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared constants and types for the reservation station:
// RV32I opcode / funct3 encodings, the stored micro-op fields and the per-entry state.
package reservation_station_pkg;

  localparam int XLEN = 32;

  // RV32I major opcodes handled by the station
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // OP / OP-IMM funct3
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // BRANCH funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Life cycle of one station entry
  typedef enum logic [1:0] {
    ENT_FREE,
    ENT_WAIT,
    ENT_READY
  } ent_state_e;

  // Decoded instruction fields kept with each entry until dispatch
  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
  } uop_t;

  // Entry state as seen from its occupancy and operand-pending flags
  function automatic ent_state_e ent_state(input logic valid, input logic qj_busy,
                                           input logic qk_busy);
    if (!valid)              return ENT_FREE;
    if (qj_busy || qk_busy)  return ENT_WAIT;
    return ENT_READY;
  endfunction

endpackage

// File: rtl/reservation_station_alu.sv
// rs_alu: purely combinational integer/branch/JALR execute unit for the reservation station.
module rs_alu
  import reservation_station_pkg::*;
(
  input  logic [6:0]      i_opcode,
  input  logic [2:0]      i_funct3,
  input  logic            i_funct7_5,
  input  logic [XLEN-1:0] i_vj,
  input  logic [XLEN-1:0] i_vk,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_result
);

  logic [XLEN-1:0] w_rk;
  logic [4:0]      w_shamt;
  logic            w_taken;
  logic [XLEN-1:0] w_arith;

  // Evaluate the selected operation; register forms use Vk, immediate forms use imm.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    w_rk     = (i_opcode == OPC_OP_IMM) ? i_imm : i_vk;
    w_shamt  = w_rk[4:0];
    w_taken  = 1'b0;
    w_arith  = '0;
    o_result = '0;

    unique case (i_funct3)
      // ADDI has no subtract form; instr[30] is an immediate bit there
      F3_ADD_SUB: w_arith = (i_opcode == OPC_OP && i_funct7_5) ? i_vj - w_rk : i_vj + w_rk;
      F3_SLL:     w_arith = i_vj << w_shamt;
      F3_SLT:     w_arith = {31'b0, $signed(i_vj) < $signed(w_rk)};
      F3_SLTU:    w_arith = {31'b0, i_vj < w_rk};
      F3_XOR:     w_arith = i_vj ^ w_rk;
      F3_SRL_SRA: w_arith = i_funct7_5 ? XLEN'($signed(i_vj) >>> w_shamt) : i_vj >> w_shamt;
      F3_OR:      w_arith = i_vj | w_rk;
      F3_AND:     w_arith = i_vj & w_rk;
      default:    w_arith = '0;
    endcase

    case (i_funct3)
      F3_BEQ:  w_taken = (i_vj == i_vk);
      F3_BNE:  w_taken = (i_vj != i_vk);
      F3_BLT:  w_taken = ($signed(i_vj) < $signed(i_vk));
      F3_BGE:  w_taken = ($signed(i_vj) >= $signed(i_vk));
      F3_BLTU: w_taken = (i_vj < i_vk);
      F3_BGEU: w_taken = (i_vj >= i_vk);
      default: w_taken = 1'b0;
    endcase

    case (i_opcode)
      OPC_OP, OPC_OP_IMM: o_result = w_arith;
      OPC_LUI:            o_result = i_imm;
      OPC_AUIPC:          o_result = i_pc + i_imm;
      OPC_JALR:           o_result = (i_vj + i_imm) & ~32'd1;
      // The ROB compares this taken flag against its prediction
      OPC_BRANCH:         o_result = {31'b0, w_taken};
      default:            o_result = '0;
    endcase
  end

endmodule

// File: rtl/reservation_station.sv
// reservation_station: holds issued integer/branch/JALR micro-ops until both operands are
// known, snoops the RS and LSB result buses, dispatches one ready entry per cycle into rs_alu
// and drives a registered result broadcast towards the ROB.
// Build option: define RS_AGE_SELECT_EN to dispatch the oldest ready entry instead of the
// lowest-indexed one.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RoB_BITS = 4,
  parameter int RS_SIZE  = 8,
  parameter int RS_BITS  = 3
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                clear,
  input  logic                issue_ready,
  input  logic [6:0]          issue_opcode,
  input  logic [2:0]          issue_funct3,
  input  logic                issue_funct7_5,
  input  logic [31:0]         issue_pc,
  input  logic [31:0]         issue_imm,
  input  logic [31:0]         issue_Vj,
  input  logic [31:0]         issue_Vk,
  input  logic                issue_Qj_busy,
  input  logic                issue_Qk_busy,
  input  logic [RoB_BITS-1:0] issue_Qj,
  input  logic [RoB_BITS-1:0] issue_Qk,
  input  logic [RoB_BITS-1:0] issue_rob_id,
  input  logic                cdb1_rdy,
  input  logic [RoB_BITS-1:0] cdb1_id,
  input  logic [31:0]         cdb1_value,
  input  logic                cdb2_rdy,
  input  logic [RoB_BITS-1:0] cdb2_id,
  input  logic [31:0]         cdb2_value,
  output logic                full,
  output logic                RS_finish_rdy,
  output logic [RoB_BITS-1:0] RS_finish_id,
  output logic [31:0]         RS_finish_value
);

  // Registered entry state
  logic [RS_SIZE-1:0]  r_valid;
  logic [RS_SIZE-1:0]  r_qj_busy;
  logic [RS_SIZE-1:0]  r_qk_busy;
  logic [RoB_BITS-1:0] r_qj  [RS_SIZE];
  logic [RoB_BITS-1:0] r_qk  [RS_SIZE];
  logic [RoB_BITS-1:0] r_rob [RS_SIZE];
  logic [31:0]         r_vj  [RS_SIZE];
  logic [31:0]         r_vk  [RS_SIZE];
  uop_t                r_uop [RS_SIZE];

  logic                r_finish_rdy;
  logic [RoB_BITS-1:0] r_finish_id;
  logic [31:0]         r_finish_value;

  // Next-state values
  logic [RS_SIZE-1:0]  w_valid_nxt;
  logic [RS_SIZE-1:0]  w_qj_busy_nxt;
  logic [RS_SIZE-1:0]  w_qk_busy_nxt;
  logic [RoB_BITS-1:0] w_qj_nxt  [RS_SIZE];
  logic [RoB_BITS-1:0] w_qk_nxt  [RS_SIZE];
  logic [RoB_BITS-1:0] w_rob_nxt [RS_SIZE];
  logic [31:0]         w_vj_nxt  [RS_SIZE];
  logic [31:0]         w_vk_nxt  [RS_SIZE];
  uop_t                w_uop_nxt [RS_SIZE];

  logic                w_finish_rdy_nxt;
  logic [RoB_BITS-1:0] w_finish_id_nxt;
  logic [31:0]         w_finish_value_nxt;

  // Selection and bypass
  ent_state_e          w_state [RS_SIZE];
  logic [RS_SIZE-1:0]  w_ready;
  logic                w_full;
  logic                w_issue_fire;
  logic [RS_BITS-1:0]  w_issue_idx;
  logic                w_disp_en;
  logic                w_disp_fire;
  logic [RS_BITS-1:0]  w_disp_idx;
  logic                w_iss_qj_busy;
  logic                w_iss_qk_busy;
  logic [31:0]         w_iss_vj;
  logic [31:0]         w_iss_vk;
  logic [31:0]         w_alu_result;
  uop_t                w_alu_uop;

`ifdef RS_AGE_SELECT_EN
  // Issue-order rank among occupied entries: 0 is the oldest
  logic [RS_BITS-1:0]  r_age     [RS_SIZE];
  logic [RS_BITS-1:0]  w_age_nxt [RS_SIZE];
  logic [RS_BITS-1:0]  w_new_age;
`endif

  // Classify every entry from its flags
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_state[i] = ent_state(r_valid[i], r_qj_busy[i], r_qk_busy[i]);
      w_ready[i] = (w_state[i] == ENT_READY);
    end
  end

  // Full reflects state at cycle start; a dispatch this cycle frees its slot only next cycle
  assign w_full       = &r_valid;
  assign w_issue_fire = issue_ready && !w_full && !clear;
  assign w_disp_fire  = w_disp_en && !clear;

  // Lowest-index free entry receives the issued micro-op
  always_comb begin
    w_issue_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_issue_idx = RS_BITS'(i);
    end
  end

  // Pick the entry to dispatch among those ready at cycle start
  always_comb begin
    w_disp_en  = 1'b0;
    w_disp_idx = '0;
`ifdef RS_AGE_SELECT_EN
    for (int i = 0; i < RS_SIZE; i++) begin
      if (w_ready[i] && (!w_disp_en || r_age[i] < r_age[w_disp_idx])) begin
        w_disp_en  = 1'b1;
        w_disp_idx = RS_BITS'(i);
      end
    end
`else
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_disp_en  = 1'b1;
        w_disp_idx = RS_BITS'(i);
      end
    end
`endif
  end

  // Resolve issued operands against results broadcast in the same cycle
  always_comb begin
    w_iss_qj_busy = issue_Qj_busy;
    w_iss_vj      = issue_Vj;
    w_iss_qk_busy = issue_Qk_busy;
    w_iss_vk      = issue_Vk;
    if (issue_Qj_busy) begin
      if (cdb1_rdy && cdb1_id == issue_Qj) begin
        w_iss_qj_busy = 1'b0;
        w_iss_vj      = cdb1_value;
      end else if (cdb2_rdy && cdb2_id == issue_Qj) begin
        w_iss_qj_busy = 1'b0;
        w_iss_vj      = cdb2_value;
      end
    end
    if (issue_Qk_busy) begin
      if (cdb1_rdy && cdb1_id == issue_Qk) begin
        w_iss_qk_busy = 1'b0;
        w_iss_vk      = cdb1_value;
      end else if (cdb2_rdy && cdb2_id == issue_Qk) begin
        w_iss_qk_busy = 1'b0;
        w_iss_vk      = cdb2_value;
      end
    end
  end

  // Execute the dispatched entry
  assign w_alu_uop = r_uop[w_disp_idx];

  rs_alu u_alu (
    .i_opcode   (w_alu_uop.opcode),
    .i_funct3   (w_alu_uop.funct3),
    .i_funct7_5 (w_alu_uop.funct7_5),
    .i_vj       (r_vj[w_disp_idx]),
    .i_vk       (r_vk[w_disp_idx]),
    .i_imm      (w_alu_uop.imm),
    .i_pc       (w_alu_uop.pc),
    .o_result   (w_alu_result)
  );

  // Next state: operand capture, dispatch release, issue write, then flush override
  always_comb begin
    // NOTE: next-state is composed with blocking assignments here; only always_ff uses <=.
    w_valid_nxt   = r_valid;
    w_qj_busy_nxt = r_qj_busy;
    w_qk_busy_nxt = r_qk_busy;
    w_qj_nxt      = r_qj;
    w_qk_nxt      = r_qk;
    w_rob_nxt     = r_rob;
    w_vj_nxt      = r_vj;
    w_vk_nxt      = r_vk;
    w_uop_nxt     = r_uop;

    for (int i = 0; i < RS_SIZE; i++) begin
      if (r_valid[i] && r_qj_busy[i]) begin
        if (cdb1_rdy && cdb1_id == r_qj[i]) begin
          w_vj_nxt[i]      = cdb1_value;
          w_qj_busy_nxt[i] = 1'b0;
        end else if (cdb2_rdy && cdb2_id == r_qj[i]) begin
          w_vj_nxt[i]      = cdb2_value;
          w_qj_busy_nxt[i] = 1'b0;
        end
      end
      if (r_valid[i] && r_qk_busy[i]) begin
        if (cdb1_rdy && cdb1_id == r_qk[i]) begin
          w_vk_nxt[i]      = cdb1_value;
          w_qk_busy_nxt[i] = 1'b0;
        end else if (cdb2_rdy && cdb2_id == r_qk[i]) begin
          w_vk_nxt[i]      = cdb2_value;
          w_qk_busy_nxt[i] = 1'b0;
        end
      end
    end

    if (w_disp_fire) w_valid_nxt[w_disp_idx] = 1'b0;

    if (w_issue_fire) begin
      w_valid_nxt[w_issue_idx]        = 1'b1;
      w_qj_busy_nxt[w_issue_idx]      = w_iss_qj_busy;
      w_qk_busy_nxt[w_issue_idx]      = w_iss_qk_busy;
      w_qj_nxt[w_issue_idx]           = issue_Qj;
      w_qk_nxt[w_issue_idx]           = issue_Qk;
      w_vj_nxt[w_issue_idx]           = w_iss_vj;
      w_vk_nxt[w_issue_idx]           = w_iss_vk;
      w_rob_nxt[w_issue_idx]          = issue_rob_id;
      w_uop_nxt[w_issue_idx].opcode   = issue_opcode;
      w_uop_nxt[w_issue_idx].funct3   = issue_funct3;
      w_uop_nxt[w_issue_idx].funct7_5 = issue_funct7_5;
      w_uop_nxt[w_issue_idx].pc       = issue_pc;
      w_uop_nxt[w_issue_idx].imm      = issue_imm;
    end

    if (clear) w_valid_nxt = '0;

    w_finish_rdy_nxt   = w_disp_fire;
    w_finish_id_nxt    = r_finish_id;
    w_finish_value_nxt = r_finish_value;
    if (w_disp_fire) begin
      w_finish_id_nxt    = r_rob[w_disp_idx];
      w_finish_value_nxt = w_alu_result;
    end
  end

`ifdef RS_AGE_SELECT_EN
  // Keep ages dense: close the gap left by a dispatch and rank a new entry last
  always_comb begin
    w_age_nxt = r_age;
    w_new_age = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_new_age = w_new_age + RS_BITS'(r_valid[i]);
    end
    if (w_disp_fire) begin
      w_new_age = w_new_age - RS_BITS'(1);
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_valid[i] && r_age[i] > r_age[w_disp_idx]) w_age_nxt[i] = r_age[i] - RS_BITS'(1);
      end
    end
    if (w_issue_fire) w_age_nxt[w_issue_idx] = w_new_age;
    if (clear) begin
      for (int i = 0; i < RS_SIZE; i++) w_age_nxt[i] = '0;
    end
  end
`endif

  // Control state and result broadcast; reset wins, rdy_in low freezes everything
  // NOTE: only the flags that qualify storage are reset; operand/payload arrays are gated by r_valid.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_valid        <= '0;
      r_qj_busy      <= '0;
      r_qk_busy      <= '0;
      r_finish_rdy   <= 1'b0;
      r_finish_id    <= '0;
      r_finish_value <= '0;
`ifdef RS_AGE_SELECT_EN
      for (int i = 0; i < RS_SIZE; i++) r_age[i] <= '0;
`endif
    end else if (rdy_in) begin
      r_valid        <= w_valid_nxt;
      r_qj_busy      <= w_qj_busy_nxt;
      r_qk_busy      <= w_qk_busy_nxt;
      r_finish_rdy   <= w_finish_rdy_nxt;
      r_finish_id    <= w_finish_id_nxt;
      r_finish_value <= w_finish_value_nxt;
`ifdef RS_AGE_SELECT_EN
      r_age          <= w_age_nxt;
`endif
    end
  end

  // Operand and micro-op payload storage
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      r_qj  <= w_qj_nxt;
      r_qk  <= w_qk_nxt;
      r_rob <= w_rob_nxt;
      r_vj  <= w_vj_nxt;
      r_vk  <= w_vk_nxt;
      r_uop <= w_uop_nxt;
    end
  end

  assign full            = w_full;
  assign RS_finish_rdy   = r_finish_rdy;
  assign RS_finish_id    = r_finish_id;
  assign RS_finish_value = r_finish_value;

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios followed by random traffic,
// all compared against an entry-list reference model held in the bench.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int ROB_W = 4;
  localparam int N     = 8;

  logic             clk_in = 1'b0;
  logic             rst_in, rdy_in, clear, issue_ready;
  logic [6:0]       issue_opcode;
  logic [2:0]       issue_funct3;
  logic             issue_funct7_5;
  logic [31:0]      issue_pc, issue_imm, issue_Vj, issue_Vk;
  logic             issue_Qj_busy, issue_Qk_busy;
  logic [ROB_W-1:0] issue_Qj, issue_Qk, issue_rob_id;
  logic             cdb1_rdy, cdb2_rdy;
  logic [ROB_W-1:0] cdb1_id, cdb2_id;
  logic [31:0]      cdb1_value, cdb2_value;
  logic             full, RS_finish_rdy;
  logic [ROB_W-1:0] RS_finish_id;
  logic [31:0]      RS_finish_value;

  always #5 clk_in = ~clk_in;

  reservation_station #(.RoB_BITS(ROB_W), .RS_SIZE(N), .RS_BITS(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .issue_ready(issue_ready), .issue_opcode(issue_opcode), .issue_funct3(issue_funct3),
    .issue_funct7_5(issue_funct7_5), .issue_pc(issue_pc), .issue_imm(issue_imm),
    .issue_Vj(issue_Vj), .issue_Vk(issue_Vk), .issue_Qj_busy(issue_Qj_busy),
    .issue_Qk_busy(issue_Qk_busy), .issue_Qj(issue_Qj), .issue_Qk(issue_Qk),
    .issue_rob_id(issue_rob_id), .cdb1_rdy(cdb1_rdy), .cdb1_id(cdb1_id),
    .cdb1_value(cdb1_value), .cdb2_rdy(cdb2_rdy), .cdb2_id(cdb2_id), .cdb2_value(cdb2_value),
    .full(full), .RS_finish_rdy(RS_finish_rdy), .RS_finish_id(RS_finish_id),
    .RS_finish_value(RS_finish_value)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model: a list of held micro-ops ----------------
  typedef struct {
    bit          valid;
    bit          qj_busy, qk_busy;
    logic [3:0]  qj, qk, rob;
    logic [31:0] vj, vk, pc, imm;
    logic [6:0]  op;
    logic [2:0]  f3;
    bit          f7;
    longint      seq;
  } m_entry_t;

  m_entry_t    m_ent [N];
  longint      m_seq_ctr = 0;
  bit          m_fin_rdy;
  logic [3:0]  m_fin_id;
  logic [31:0] m_fin_val;

  function automatic logic [31:0] ref_result(input m_entry_t e);
    logic [31:0] b;
    b = (e.op == OPC_OP_IMM) ? e.imm : e.vk;
    case (e.op)
      OPC_OP, OPC_OP_IMM:
        case (e.f3)
          3'd0: return (e.op == OPC_OP && e.f7) ? e.vj - b : e.vj + b;
          3'd1: return e.vj << b[4:0];
          3'd2: return ($signed(e.vj) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: return (e.vj < b) ? 32'd1 : 32'd0;
          3'd4: return e.vj ^ b;
          3'd5: return e.f7 ? 32'($signed(e.vj) >>> b[4:0]) : e.vj >> b[4:0];
          3'd6: return e.vj | b;
          default: return e.vj & b;
        endcase
      OPC_LUI:   return e.imm;
      OPC_AUIPC: return e.pc + e.imm;
      OPC_JALR:  return (e.vj + e.imm) & 32'hFFFF_FFFE;
      OPC_BRANCH:
        case (e.f3)
          3'd0: return (e.vj == e.vk) ? 32'd1 : 32'd0;
          3'd1: return (e.vj != e.vk) ? 32'd1 : 32'd0;
          3'd4: return ($signed(e.vj) <  $signed(e.vk)) ? 32'd1 : 32'd0;
          3'd5: return ($signed(e.vj) >= $signed(e.vk)) ? 32'd1 : 32'd0;
          3'd6: return (e.vj <  e.vk) ? 32'd1 : 32'd0;
          3'd7: return (e.vj >= e.vk) ? 32'd1 : 32'd0;
          default: return 32'd0;
        endcase
      default: return 32'd0;
    endcase
  endfunction

  // Value for a tag if either result bus carries it this cycle
  task automatic bus_lookup(input logic [3:0] tag, output bit hit, output logic [31:0] val);
    hit = 1'b0;
    val = '0;
    if (cdb1_rdy && cdb1_id == tag) begin hit = 1'b1; val = cdb1_value; end
    else if (cdb2_rdy && cdb2_id == tag) begin hit = 1'b1; val = cdb2_value; end
  endtask

  function automatic bit m_all_held();
    foreach (m_ent[i]) if (!m_ent[i].valid) return 1'b0;
    return 1'b1;
  endfunction

  // Advance the model by one clock using the inputs presented now
  task automatic model_step();
    int d, f;
    bit hit;
    logic [31:0] v;
    if (rst_in) begin
      foreach (m_ent[i]) m_ent[i].valid = 1'b0;
      m_fin_rdy = 1'b0; m_fin_id = '0; m_fin_val = '0;
      return;
    end
    if (!rdy_in) return;
    if (clear) begin
      foreach (m_ent[i]) m_ent[i].valid = 1'b0;
      m_fin_rdy = 1'b0;
      return;
    end
    d = -1;
    f = -1;
    foreach (m_ent[i]) begin
      if (m_ent[i].valid && !m_ent[i].qj_busy && !m_ent[i].qk_busy) begin
`ifdef RS_AGE_SELECT_EN
        if (d < 0 || m_ent[i].seq < m_ent[d].seq) d = i;
`else
        if (d < 0) d = i;
`endif
      end
      if (!m_ent[i].valid && f < 0) f = i;
    end
    foreach (m_ent[i]) begin
      if (m_ent[i].valid && m_ent[i].qj_busy) begin
        bus_lookup(m_ent[i].qj, hit, v);
        if (hit) begin m_ent[i].qj_busy = 1'b0; m_ent[i].vj = v; end
      end
      if (m_ent[i].valid && m_ent[i].qk_busy) begin
        bus_lookup(m_ent[i].qk, hit, v);
        if (hit) begin m_ent[i].qk_busy = 1'b0; m_ent[i].vk = v; end
      end
    end
    if (d >= 0) begin
      m_fin_rdy = 1'b1;
      m_fin_id  = m_ent[d].rob;
      m_fin_val = ref_result(m_ent[d]);
      m_ent[d].valid = 1'b0;
    end else begin
      m_fin_rdy = 1'b0;
    end
    if (issue_ready && f >= 0) begin
      m_ent[f].valid = 1'b1;
      m_ent[f].op = issue_opcode; m_ent[f].f3 = issue_funct3; m_ent[f].f7 = issue_funct7_5;
      m_ent[f].pc = issue_pc; m_ent[f].imm = issue_imm; m_ent[f].rob = issue_rob_id;
      m_ent[f].qj = issue_Qj; m_ent[f].qk = issue_Qk;
      m_ent[f].qj_busy = issue_Qj_busy; m_ent[f].vj = issue_Vj;
      m_ent[f].qk_busy = issue_Qk_busy; m_ent[f].vk = issue_Vk;
      if (issue_Qj_busy) begin
        bus_lookup(issue_Qj, hit, v);
        if (hit) begin m_ent[f].qj_busy = 1'b0; m_ent[f].vj = v; end
      end
      if (issue_Qk_busy) begin
        bus_lookup(issue_Qk, hit, v);
        if (hit) begin m_ent[f].qk_busy = 1'b0; m_ent[f].vk = v; end
      end
      m_ent[f].seq = m_seq_ctr++;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; issue_ready = 1'b0;
    issue_opcode = '0; issue_funct3 = '0; issue_funct7_5 = 1'b0; issue_pc = '0; issue_imm = '0;
    issue_Vj = '0; issue_Vk = '0; issue_Qj_busy = 1'b0; issue_Qk_busy = 1'b0;
    issue_Qj = '0; issue_Qk = '0; issue_rob_id = '0;
    cdb1_rdy = 1'b0; cdb1_id = '0; cdb1_value = '0;
    cdb2_rdy = 1'b0; cdb2_id = '0; cdb2_value = '0;
  endtask

  task automatic set_issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] vj, input logic [31:0] vk,
                           input logic qjb, input logic [3:0] qj,
                           input logic qkb, input logic [3:0] qk, input logic [3:0] rob);
    issue_ready = 1'b1; issue_opcode = op; issue_funct3 = f3; issue_funct7_5 = f7;
    issue_pc = pc; issue_imm = imm; issue_Vj = vj; issue_Vk = vk;
    issue_Qj_busy = qjb; issue_Qj = qj; issue_Qk_busy = qkb; issue_Qk = qk; issue_rob_id = rob;
  endtask

  // One clock: check full before the edge, advance the model, check the broadcast after it
  task automatic step(input string tag);
    check({tag, "_full"}, {31'b0, full}, {31'b0, m_all_held()});
    model_step();
    @(posedge clk_in);
    #1;
    check({tag, "_rdy"}, {31'b0, RS_finish_rdy}, {31'b0, m_fin_rdy});
    if (m_fin_rdy) begin
      check({tag, "_id"}, {28'b0, RS_finish_id}, {28'b0, m_fin_id});
      check({tag, "_val"}, RS_finish_value, m_fin_val);
    end
  endtask

  logic [6:0] ops [6];

  initial begin
    ops = '{OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_BRANCH, OPC_JALR};

    // Reset dominates clear and a low rdy_in
    idle();
    rst_in = 1'b1; clear = 1'b1; rdy_in = 1'b0;
    model_step();
    @(posedge clk_in);
    #1;
    check("rst_rdy", {31'b0, RS_finish_rdy}, 32'd0);
    check("rst_id", {28'b0, RS_finish_id}, 32'd0);
    check("rst_val", RS_finish_value, 32'd0);
    check("rst_full", {31'b0, full}, 32'd0);

    // ADDI 5 + 7 -> 12, two cycles after issue
    idle();
    set_issue(OPC_OP_IMM, F3_ADD_SUB, 1'b0, 32'h0, 32'd7, 32'd5, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    step("addi_iss");
    check("addi_early", {31'b0, RS_finish_rdy}, 32'd0);
    idle();
    step("addi_disp");
    check("addi_rdy", {31'b0, RS_finish_rdy}, 32'd1);
    check("addi_id", {28'b0, RS_finish_id}, 32'd3);
    check("addi_val", RS_finish_value, 32'd12);

    // SUB waiting on tag 2, resolved by the LSB bus two cycles later
    idle();
    set_issue(OPC_OP, F3_ADD_SUB, 1'b1, 32'h0, 32'h0, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd5);
    step("sub_iss");
    idle();
    step("sub_wait");
    idle();
    cdb2_rdy = 1'b1; cdb2_id = 4'd2; cdb2_value = 32'd10;
    step("sub_cap");
    check("sub_not_before", {31'b0, RS_finish_rdy}, 32'd0);
    idle();
    step("sub_disp");
    check("sub_val", RS_finish_value, 32'd9);

    // Operand resolved by cdb1 during the issue cycle itself
    idle();
    set_issue(OPC_OP, F3_ADD_SUB, 1'b0, 32'h0, 32'h0, 32'd0, 32'd1, 1'b1, 4'd4, 1'b0, 4'd0, 4'd6);
    cdb1_rdy = 1'b1; cdb1_id = 4'd4; cdb1_value = 32'hFFFF_FFFF;
    step("byp_iss");
    idle();
    step("byp_disp");
    check("byp_rdy", {31'b0, RS_finish_rdy}, 32'd1);
    check("byp_val", RS_finish_value, 32'd0);

    // Fill every entry, try a ninth issue, then release them all at once
    for (int i = 0; i < N; i++) begin
      idle();
      set_issue(OPC_OP, F3_ADD_SUB, 1'b0, 32'h0, 32'h0, 32'd0, 32'(i), 1'b1, 4'd7, 1'b0, 4'd0, 4'(i));
      step("fill_iss");
    end
    check("fill_full", {31'b0, full}, 32'd1);
    idle();
    set_issue(OPC_LUI, 3'd0, 1'b0, 32'h0, 32'hDEAD_0000, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    step("fill_ninth");
    check("fill_still_full", {31'b0, full}, 32'd1);
    idle();
    cdb2_rdy = 1'b1; cdb2_id = 4'd7; cdb2_value = 32'd100;
    step("fill_cap");
    for (int i = 0; i < N; i++) begin
      idle();
      step("fill_drain");
      check($sformatf("drain%0d_id", i), {28'b0, RS_finish_id}, 32'(i));
      check($sformatf("drain%0d_val", i), RS_finish_value, 32'(100 + i));
      if (i == 0) check("drain_full_drop", {31'b0, full}, 32'd0);
    end
    idle();
    step("fill_after");
    check("ninth_dropped", {31'b0, RS_finish_rdy}, 32'd0);

    // Branch and JALR results
    idle();
    set_issue(OPC_BRANCH, F3_BLTU, 1'b0, 32'h40, 32'h8, 32'd1, 32'hFFFF_FFFF, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
    step("bltu_iss");
    idle();
    step("bltu_disp");
    check("bltu_val", RS_finish_value, 32'd1);
    set_issue(OPC_BRANCH, F3_BGE, 1'b0, 32'h44, 32'h8, 32'd1, 32'hFFFF_FFFF, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
    step("bge_iss");
    idle();
    step("bge_disp");
    check("bge_val", RS_finish_value, 32'd1);
    set_issue(OPC_JALR, 3'd0, 1'b0, 32'h48, 32'd2, 32'h101, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    step("jalr_iss");
    idle();
    step("jalr_disp");
    check("jalr_val", RS_finish_value, 32'h102);

    // Flush with three waiting entries and one ready to dispatch
    for (int i = 0; i < 3; i++) begin
      idle();
      set_issue(OPC_OP, F3_XOR, 1'b0, 32'h0, 32'h0, 32'd0, 32'd3, 1'b1, 4'd9, 1'b0, 4'd0, 4'(10 + i));
      step("clr_fill");
    end
    idle();
    set_issue(OPC_OP_IMM, F3_ADD_SUB, 1'b0, 32'h0, 32'd1, 32'd1, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd13);
    step("clr_ready");
    idle();
    clear = 1'b1;
    set_issue(OPC_LUI, 3'd0, 1'b0, 32'h0, 32'h1234_0000, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd14);
    step("clr_flush");
    check("clr_rdy", {31'b0, RS_finish_rdy}, 32'd0);
    check("clr_full", {31'b0, full}, 32'd0);
    idle();
    cdb1_rdy = 1'b1; cdb1_id = 4'd9; cdb1_value = 32'd55;
    step("clr_bcast");
    for (int i = 0; i < 3; i++) begin
      idle();
      step("clr_after");
      check("clr_no_result", {31'b0, RS_finish_rdy}, 32'd0);
    end

    // rdy_in low freezes state and the broadcast register
    idle();
    set_issue(OPC_OP_IMM, F3_ADD_SUB, 1'b0, 32'h0, 32'd1, 32'd1, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd14);
    step("hold_iss");
    idle();
    rdy_in = 1'b0;
    step("hold_frozen");
    check("hold_no_disp", {31'b0, RS_finish_rdy}, 32'd0);
    idle();
    step("hold_release");
    check("hold_val", RS_finish_value, 32'd2);
    idle();
    rdy_in = 1'b0;
    step("hold_out");
    check("hold_out_rdy", {31'b0, RS_finish_rdy}, 32'd1);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      idle();
      rdy_in = ($urandom_range(0, 9) != 0);
      clear  = ($urandom_range(0, 49) == 0);
      rst_in = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 9) < 6) begin
        issue_ready    = 1'b1;
        issue_opcode   = ops[$urandom_range(0, 5)];
        issue_funct3   = 3'($urandom_range(0, 7));
        if (issue_opcode == OPC_BRANCH && (issue_funct3 == 3'd2 || issue_funct3 == 3'd3))
          issue_funct3 = 3'd0;
        issue_funct7_5 = 1'($urandom_range(0, 1));
        issue_pc       = $urandom();
        issue_imm      = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom();
        issue_Vj       = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom();
        issue_Vk       = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom();
        issue_Qj_busy  = ($urandom_range(0, 2) == 0);
        issue_Qk_busy  = ($urandom_range(0, 2) == 0);
        issue_Qj       = 4'($urandom_range(0, 7));
        issue_Qk       = 4'($urandom_range(0, 7));
        issue_rob_id   = 4'($urandom_range(0, 15));
      end
      cdb1_rdy   = ($urandom_range(0, 2) == 0);
      cdb1_id    = 4'($urandom_range(0, 7));
      cdb1_value = $urandom();
      cdb2_rdy   = ($urandom_range(0, 2) == 0);
      cdb2_id    = 4'($urandom_range(0, 7));
      cdb2_value = $urandom();
      if (cdb1_rdy && cdb2_rdy && cdb1_id == cdb2_id) cdb2_id = cdb1_id ^ 4'd1;
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
